// File: rtl/dcf77_frame_receiver.sv
// dcf77_frame_receiver
// Derives a 1 ms tick from qzt_clk, classifies DCF77 pulse widths, locks on
// the minute marker, assembles and parity-checks the 59-bit frame and
// publishes it with a one-cycle valid strobe. Also reports carrier loss.
// Optional build macro: DCF77_LEAP_SECOND_EN accepts the 60-bit leap minute
// after a valid frame that announced it (bit 19).
module dcf77_frame_receiver #(
    parameter int TICK_DIV    = 50000,
    parameter int BIT0_MIN_MS = 60,
    parameter int BIT0_MAX_MS = 140,
    parameter int BIT1_MIN_MS = 160,
    parameter int BIT1_MAX_MS = 240,
    parameter int MARK_MIN_MS = 1500,
    parameter int LOSS_MS     = 2500,
    parameter int CNT_W       = 12
) (
    input  logic        qzt_clk,
    input  logic        reset_n,
    input  logic        sgn_in,
    input  logic        enable_sincro,
    output logic [58:0] frame_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        sincro,
    output logic [5:0]  bit_index,
    output logic        bit_strobe,
    output logic        bit_value,
    output logic        carrier_lost
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  B0_MIN    = CNT_W'(BIT0_MIN_MS);
    localparam logic [CNT_W-1:0]  B0_MAX    = CNT_W'(BIT0_MAX_MS);
    localparam logic [CNT_W-1:0]  B1_MIN    = CNT_W'(BIT1_MIN_MS);
    localparam logic [CNT_W-1:0]  B1_MAX    = CNT_W'(BIT1_MAX_MS);
    localparam logic [CNT_W-1:0]  MARK_MIN  = CNT_W'(MARK_MIN_MS);
    localparam logic [CNT_W-1:0]  LOSS_MIN  = CNT_W'(LOSS_MS);

    typedef enum logic [1:0] {HUNT, RECV, CHECK} state_t;
    state_t state, state_nxt;

    logic              sgn_p0, sgn_p1, sgn_p2;
    logic              rise, fall;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [CNT_W-1:0]  high_cnt, low_cnt;
    logic [58:0]       shadow;
    logic [5:0]        bit_cnt;
    logic              is_bit0, is_bit1, good_bit, bad_bit, marker;
    logic              loss_lvl, loss;
    logic              frame_ok, leap_ok, count_ok;
    logic              valid_d, err_d, strobe_d, bit_wr, cnt_clr;
    logic              sincro_set, sincro_clr, publish;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Two-flop synchroniser followed by the edge-detector register
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            sgn_p0 <= 1'b0;
            sgn_p1 <= 1'b0;
            sgn_p2 <= 1'b0;
        end else begin
            sgn_p0 <= sgn_in;
            sgn_p1 <= sgn_p0;
            sgn_p2 <= sgn_p1;
        end
    end

    assign rise = sgn_p1 & ~sgn_p2;
    assign fall = ~sgn_p1 & sgn_p2;

    // Millisecond tick divider
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n)                tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                         tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Saturating high/low width counters; each restarts on the edge that ends its level's meaning
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            if (fall)                 high_cnt <= '0;
            else if (tick && sgn_p1)  high_cnt <= sat_inc(high_cnt);
            if (rise)                 low_cnt  <= '0;
            else if (tick && !sgn_p1) low_cnt  <= sat_inc(low_cnt);
        end
    end

    assign is_bit0  = (high_cnt >= B0_MIN) && (high_cnt <= B0_MAX);
    assign is_bit1  = (high_cnt >= B1_MIN) && (high_cnt <= B1_MAX);
    assign good_bit = fall && (is_bit0 || is_bit1);
    assign bad_bit  = fall && !(is_bit0 || is_bit1);
    assign marker   = rise && (low_cnt >= MARK_MIN);
    assign loss_lvl = (low_cnt >= LOSS_MIN) || (high_cnt >= LOSS_MIN);
    assign loss     = loss_lvl && !rise && !fall;
    assign count_ok = (bit_cnt == 6'd59) || (leap_ok && bit_cnt == 6'd60);

`ifdef DCF77_LEAP_SECOND_EN
    logic leap_pending, bit59;
    assign leap_ok = leap_pending;

    // Leap announcement is latched from a good frame and consumed by the 60-bit minute
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            leap_pending <= 1'b0;
            bit59        <= 1'b0;
        end else begin
            if (bit_wr && bit_cnt == 6'd59) bit59 <= is_bit1;
            if (state == CHECK && enable_sincro) begin
                if (bit_cnt == 6'd60) leap_pending <= 1'b0;
                else if (frame_ok)    leap_pending <= shadow[19];
            end
        end
    end
`else
    assign leap_ok = 1'b0;
`endif

    // Frame acceptance: fixed start/time bits plus three even-parity groups
    always_comb begin
        frame_ok = ~shadow[0] & shadow[20] & ~(^shadow[28:21])
                 & ~(^shadow[35:29]) & ~(^shadow[58:36]);
`ifdef DCF77_LEAP_SECOND_EN
        if (bit_cnt == 6'd60 && bit59) frame_ok = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) state <= HUNT;
        else          state <= state_nxt;
    end

    // Next-state and strobe decode; disable and carrier loss override everything
    always_comb begin
        state_nxt  = state;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        strobe_d   = 1'b0;
        bit_wr     = 1'b0;
        cnt_clr    = 1'b0;
        sincro_set = 1'b0;
        sincro_clr = 1'b0;
        publish    = 1'b0;
        if (!enable_sincro || loss) begin
            state_nxt  = HUNT;
            sincro_clr = 1'b1;
        end else begin
            case (state)
                HUNT: begin
                    if (marker) begin
                        state_nxt = RECV;
                        cnt_clr   = 1'b1;
                    end
                end
                RECV: begin
                    if (marker) begin
                        if (count_ok) begin
                            state_nxt = CHECK;
                        end else begin
                            err_d      = 1'b1;
                            cnt_clr    = 1'b1;
                            sincro_clr = 1'b1;
                        end
                    end else if (bad_bit) begin
                        err_d      = 1'b1;
                        sincro_clr = 1'b1;
                        state_nxt  = HUNT;
                    end else if (good_bit) begin
                        if (bit_cnt < 6'd59 || (leap_ok && bit_cnt == 6'd59)) begin
                            strobe_d = 1'b1;
                            bit_wr   = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            sincro_clr = 1'b1;
                            state_nxt  = HUNT;
                        end
                    end
                end
                CHECK: begin
                    state_nxt = RECV;
                    cnt_clr   = 1'b1;
                    if (frame_ok) begin
                        valid_d    = 1'b1;
                        sincro_set = 1'b1;
                        publish    = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        sincro_clr = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Shadow assembly, published frame and registered strobes/levels
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow       <= '0;
            bit_cnt      <= '0;
            bit_index    <= '0;
            bit_value    <= 1'b0;
            bit_strobe   <= 1'b0;
            frame_out    <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            sincro       <= 1'b0;
            carrier_lost <= 1'b0;
        end else begin
            frame_valid <= valid_d;
            frame_err   <= err_d;
            bit_strobe  <= strobe_d;
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (bit_wr) begin
                bit_cnt   <= bit_cnt + 1'b1;
                bit_index <= bit_cnt;
                bit_value <= is_bit1;
                if (bit_cnt < 6'd59) shadow[bit_cnt] <= is_bit1;
            end
            if (publish)         frame_out <= shadow;
            if (sincro_set)      sincro <= 1'b1;
            else if (sincro_clr) sincro <= 1'b0;
            if (!enable_sincro || rise || fall) carrier_lost <= 1'b0;
            else if (loss_lvl)                  carrier_lost <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dcf77_frame_receiver.sv
// Testbench for dcf77_frame_receiver with scaled-down millisecond parameters.
module tb_dcf77_frame_receiver;
    localparam int TD    = 2;
    localparam int B0MIN = 6;
    localparam int B0MAX = 14;
    localparam int B1MIN = 16;
    localparam int B1MAX = 24;
    localparam int MARK  = 150;
    localparam int LOSS  = 250;

    logic        qzt_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sgn_in = 1'b0;
    logic        enable_sincro = 1'b1;
    logic [58:0] frame_out;
    logic        frame_valid, frame_err, sincro, bit_strobe, bit_value, carrier_lost;
    logic [5:0]  bit_index;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int strobe_cnt = 0;
    int strobe_idx[$];
    logic strobe_val[$];

    always #5 qzt_clk = ~qzt_clk;

    dcf77_frame_receiver #(
        .TICK_DIV(TD), .BIT0_MIN_MS(B0MIN), .BIT0_MAX_MS(B0MAX),
        .BIT1_MIN_MS(B1MIN), .BIT1_MAX_MS(B1MAX), .MARK_MIN_MS(MARK),
        .LOSS_MS(LOSS), .CNT_W(12)
    ) dut (
        .qzt_clk(qzt_clk), .reset_n(reset_n), .sgn_in(sgn_in),
        .enable_sincro(enable_sincro), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_err(frame_err), .sincro(sincro),
        .bit_index(bit_index), .bit_strobe(bit_strobe), .bit_value(bit_value),
        .carrier_lost(carrier_lost)
    );

    // Event recorder for strobes
    always @(negedge qzt_clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        if (bit_strobe) begin
            strobe_cnt++;
            strobe_idx.push_back(int'(bit_index));
            strobe_val.push_back(bit_value);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic ones_odd(input logic [59:0] f, input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (f[i]) c++;
        return (c % 2) == 1;
    endfunction

    function automatic logic [59:0] make_frame(input logic [6:0] minute, input logic [5:0] hour,
                                               input logic leap_ann);
        logic [59:0] f;
        f = '0;
        for (int i = 1; i <= 18; i++) f[i] = 1'($urandom_range(0, 1));
        f[19] = leap_ann;
        f[20] = 1'b1;
        f[27:21] = minute;
        f[28] = ones_odd(f, 21, 27);
        f[34:29] = hour;
        f[35] = ones_odd(f, 29, 34);
        for (int i = 36; i <= 57; i++) f[i] = 1'($urandom_range(0, 1));
        f[58] = ones_odd(f, 36, 57);
        return f;
    endfunction

    function automatic logic frame_passes(input logic [59:0] f, input int nbits);
        if (f[0] !== 1'b0 || f[20] !== 1'b1) return 1'b0;
        if (ones_odd(f, 21, 28) || ones_odd(f, 29, 35) || ones_odd(f, 36, 58)) return 1'b0;
        if (nbits == 60 && f[59]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [6:0] rand_minute();
        logic [2:0] t;
        logic [3:0] u;
        t = 3'($urandom_range(0, 5));
        u = 4'($urandom_range(0, 9));
        return {t, u};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_ticks(input int n);
        repeat (n * TD) @(negedge qzt_clk);
    endtask

    task automatic send_bits(input logic [59:0] f, input int n, input logic last_marker);
        for (int i = 0; i < n; i++) begin
            sgn_in = 1'b1;
            wait_ticks(f[i] ? int'($urandom_range(18, 22)) : int'($urandom_range(8, 12)));
            sgn_in = 1'b0;
            wait_ticks((last_marker && i == n - 1) ? int'($urandom_range(170, 200))
                                                    : int'($urandom_range(15, 25)));
        end
    endtask

    task automatic close_pulse();
        sgn_in = 1'b1;
        wait_ticks(10);
        sgn_in = 1'b0;
        wait_ticks(5);
    endtask

    task automatic go_idle();
        sgn_in = 1'b0;
        wait_ticks(LOSS + 20);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [59:0] f;
        int s0;
        repeat (4) @(negedge qzt_clk);
        n_cmp++;
        if ({frame_out, frame_valid, frame_err, sincro, bit_index, bit_strobe, bit_value, carrier_lost} !== '0) begin
            n_bad++;
            $display("FAIL reset_initial outputs got %h want 0", frame_out);
        end
        reset_n = 1'b1;
        go_idle();
        f = make_frame(7'h11, 6'h02, 1'b0);
        send_bits(f, 10, 1'b0);
        sgn_in = 1'b1;
        wait_ticks(3);
        reset_n = 1'b0;
        repeat (2) @(negedge qzt_clk);
        n_cmp++;
        if ({frame_valid, frame_err, sincro, bit_index, bit_strobe, bit_value, carrier_lost} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_stream ctrl got idx=%0d sincro=%b want all 0", bit_index, sincro);
        end
        n_cmp++;
        if (frame_out !== 59'd0) begin
            n_bad++;
            $display("FAIL reset_mid_stream frame_out got %h want 0", frame_out);
        end
        reset_n = 1'b1;
        sgn_in = 1'b0;
        wait_ticks(20);
        s0 = strobe_cnt;
        send_bits(f, 5, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 !== 0) begin
            n_bad++;
            $display("FAIL reset_hunt strobes got %0d want 0", strobe_cnt - s0);
        end
        go_idle();
    endtask

    task automatic test_valid_frame();
        logic [59:0] f;
        int v0, e0, bad, exp_v;
        f = make_frame(7'h25, 6'h13, 1'b0);
        exp_v = frame_passes(f, 59) ? 1 : 0;
        v0 = valid_cnt; e0 = err_cnt;
        strobe_idx.delete(); strobe_val.delete();
        send_bits(f, 59, 1'b1);
        close_pulse();
        n_cmp++;
        if (valid_cnt - v0 !== exp_v) begin
            n_bad++; $display("FAIL valid_frame.valid_count got %0d want %0d", valid_cnt - v0, exp_v);
        end
        n_cmp++;
        if (err_cnt - e0 !== 1 - exp_v) begin
            n_bad++; $display("FAIL valid_frame.err_count got %0d want %0d", err_cnt - e0, 1 - exp_v);
        end
        n_cmp++;
        if (frame_out !== f[58:0]) begin
            n_bad++; $display("FAIL valid_frame.frame_out got %h want %h", frame_out, f[58:0]);
        end
        n_cmp++;
        if (frame_out[27:21] !== 7'h25) begin
            n_bad++; $display("FAIL valid_frame.minute got %h want 25", frame_out[27:21]);
        end
        n_cmp++;
        if (sincro !== 1'b1) begin
            n_bad++; $display("FAIL valid_frame.sincro got %b want 1", sincro);
        end
        bad = 0;
        if (strobe_idx.size() < 59) bad = 59;
        else for (int i = 0; i < 59; i++)
            if (strobe_idx[i] != i || strobe_val[i] !== f[i]) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL valid_frame.bit_strobes got %0d bad entries want 0", bad);
        end
        go_idle();
    endtask

    task automatic test_parity_error();
        logic [59:0] g, b;
        int v0, e0;
        g = make_frame(7'h25, 6'h13, 1'b0);
        b = g;
        b[22] = ~b[22];
        v0 = valid_cnt; e0 = err_cnt;
        send_bits(g, 59, 1'b1);
        send_bits(b, 59, 1'b1);
        close_pulse();
        n_cmp++;
        if (valid_cnt - v0 !== 32'(frame_passes(g, 59)) + 32'(frame_passes(b, 59))) begin
            n_bad++; $display("FAIL parity.valid_count got %0d want 1", valid_cnt - v0);
        end
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL parity.err_count got %0d want 1", err_cnt - e0);
        end
        n_cmp++;
        if (sincro !== 1'b0) begin
            n_bad++; $display("FAIL parity.sincro got %b want 0", sincro);
        end
        n_cmp++;
        if (frame_out !== g[58:0]) begin
            n_bad++; $display("FAIL parity.frame_out got %h want %h", frame_out, g[58:0]);
        end
        go_idle();
    endtask

    task automatic test_random_frames();
        logic [59:0] f;
        logic [58:0] exp_out;
        logic last_pass;
        int v0, e0, exp_v, exp_e;
        exp_out = frame_out;
        v0 = valid_cnt; e0 = err_cnt;
        exp_v = 0; exp_e = 0; last_pass = 1'b0;
        for (int k = 0; k < 3; k++) begin
            f = make_frame(rand_minute(), 6'($urandom_range(0, 23)), 1'b0);
            if ($urandom_range(0, 1) == 1) f[$urandom_range(0, 58)] ^= 1'b1;
            last_pass = frame_passes(f, 59);
            if (last_pass) begin exp_v++; exp_out = f[58:0]; end
            else exp_e++;
            send_bits(f, 59, 1'b1);
        end
        close_pulse();
        n_cmp++;
        if (valid_cnt - v0 !== exp_v) begin
            n_bad++; $display("FAIL random.valid_count got %0d want %0d", valid_cnt - v0, exp_v);
        end
        n_cmp++;
        if (err_cnt - e0 !== exp_e) begin
            n_bad++; $display("FAIL random.err_count got %0d want %0d", err_cnt - e0, exp_e);
        end
        n_cmp++;
        if (frame_out !== exp_out) begin
            n_bad++; $display("FAIL random.frame_out got %h want %h", frame_out, exp_out);
        end
        n_cmp++;
        if (sincro !== last_pass) begin
            n_bad++; $display("FAIL random.sincro got %b want %b", sincro, last_pass);
        end
        go_idle();
    endtask

    task automatic test_bad_pulse();
        logic [59:0] f;
        int e0, s0;
        f = make_frame(7'h42, 6'h07, 1'b0);
        e0 = err_cnt;
        send_bits(f, 20, 1'b0);
        sgn_in = 1'b1;
        wait_ticks(30);
        sgn_in = 1'b0;
        wait_ticks(3);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL bad_pulse.err_count got %0d want 1", err_cnt - e0);
        end
        n_cmp++;
        if (sincro !== 1'b0) begin
            n_bad++; $display("FAIL bad_pulse.sincro got %b want 0", sincro);
        end
        s0 = strobe_cnt;
        send_bits(f, 5, 1'b0);
        n_cmp++;
        if (strobe_cnt - s0 !== 0) begin
            n_bad++; $display("FAIL bad_pulse.hunt_strobes got %0d want 0", strobe_cnt - s0);
        end
        go_idle();
    endtask

    task automatic test_carrier_loss();
        logic [59:0] f;
        f = make_frame(rand_minute(), 6'h09, 1'b0);
        send_bits(f, 59, 1'b1);
        close_pulse();
        wait_ticks(LOSS - 15);
        n_cmp++;
        if (carrier_lost !== 1'b0 || sincro !== 1'b1) begin
            n_bad++; $display("FAIL loss.before got lost=%b sincro=%b want 0/1", carrier_lost, sincro);
        end
        wait_ticks(20);
        n_cmp++;
        if (carrier_lost !== 1'b1) begin
            n_bad++; $display("FAIL loss.after got %b want 1", carrier_lost);
        end
        n_cmp++;
        if (sincro !== 1'b0) begin
            n_bad++; $display("FAIL loss.sincro got %b want 0", sincro);
        end
        sgn_in = 1'b1;
        wait_ticks(4);
        n_cmp++;
        if (carrier_lost !== 1'b0) begin
            n_bad++; $display("FAIL loss.clear got %b want 0", carrier_lost);
        end
        wait_ticks(6);
        go_idle();
    endtask

    task automatic test_leap();
        logic [59:0] f1, f2;
        logic [58:0] exp_out;
        logic leap_en, p1, p2;
        int v0, e0, exp_v, exp_e;
`ifdef DCF77_LEAP_SECOND_EN
        leap_en = 1'b1;
`else
        leap_en = 1'b0;
`endif
        f1 = make_frame(7'h59, 6'h00, 1'b1);
        f2 = make_frame(7'h00, 6'h01, 1'b1);
        f2[59] = 1'b0;
        exp_out = frame_out;
        p1 = frame_passes(f1, 59);
        exp_v = 0; exp_e = 0;
        if (p1) begin exp_v++; exp_out = f1[58:0]; end else exp_e++;
        if (leap_en && p1 && f1[19]) begin
            p2 = frame_passes(f2, 60);
            if (p2) begin exp_v++; exp_out = f2[58:0]; end else exp_e++;
        end else begin
            exp_e++;
        end
        v0 = valid_cnt; e0 = err_cnt;
        send_bits(f1, 59, 1'b1);
        send_bits(f2, 60, 1'b1);
        close_pulse();
        n_cmp++;
        if (valid_cnt - v0 !== exp_v) begin
            n_bad++; $display("FAIL leap.valid_count got %0d want %0d", valid_cnt - v0, exp_v);
        end
        n_cmp++;
        if (err_cnt - e0 !== exp_e) begin
            n_bad++; $display("FAIL leap.err_count got %0d want %0d", err_cnt - e0, exp_e);
        end
        n_cmp++;
        if (frame_out !== exp_out) begin
            n_bad++; $display("FAIL leap.frame_out got %h want %h", frame_out, exp_out);
        end
        go_idle();
    endtask

    task automatic test_enable();
        logic [59:0] f;
        logic [58:0] prev;
        int v0, e0, s0;
        prev = frame_out;
        enable_sincro = 1'b0;
        f = make_frame(rand_minute(), 6'h21, 1'b0);
        v0 = valid_cnt; e0 = err_cnt; s0 = strobe_cnt;
        send_bits(f, 59, 1'b1);
        close_pulse();
        go_idle();
        n_cmp++;
        if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0 || strobe_cnt - s0 !== 0) begin
            n_bad++; $display("FAIL enable.strobes got v=%0d e=%0d s=%0d want 0", valid_cnt - v0, err_cnt - e0, strobe_cnt - s0);
        end
        n_cmp++;
        if (sincro !== 1'b0 || carrier_lost !== 1'b0) begin
            n_bad++; $display("FAIL enable.levels got sincro=%b lost=%b want 0/0", sincro, carrier_lost);
        end
        n_cmp++;
        if (frame_out !== prev) begin
            n_bad++; $display("FAIL enable.frame_out got %h want %h", frame_out, prev);
        end
        enable_sincro = 1'b1;
        wait_ticks(5);
    endtask

    task automatic test_reset_mid_frame();
        logic [59:0] f;
        f = make_frame(7'h33, 6'h12, 1'b0);
        send_bits(f, 59, 1'b1);
        send_bits(f, 30, 1'b0);
        n_cmp++;
        if (frame_out !== f[58:0]) begin
            n_bad++; $display("FAIL reset_mid_frame.before got %h want %h", frame_out, f[58:0]);
        end
        sgn_in = 1'b1;
        wait_ticks(4);
        reset_n = 1'b0;
        repeat (2) @(negedge qzt_clk);
        n_cmp++;
        if (frame_out !== 59'd0 || sincro !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_frame.after got %h sincro=%b want 0", frame_out, sincro);
        end
        reset_n = 1'b1;
        sgn_in = 1'b0;
        wait_ticks(5);
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_parity_error();
        test_random_frames();
        test_bad_pulse();
        test_carrier_loss();
        test_leap();
        test_enable();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
